// File: rtl/iq_param_pkg.sv
// Shared constants for the instruction queue between fetcher and decoder.
package iq_param_pkg;

  localparam int INSTR_LENGTH = 32;
  localparam int PC_LENGTH    = 32;
  localparam int IQ_DEPTH     = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Byte distance between consecutive fetched instructions.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/iq_param_ram.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
module iq_param_ram
  import iq_param_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = 4,
  parameter int W     = INSTR_LENGTH + PC_LENGTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  // No reset: a flush or reset only moves pointers, stale data is never read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iq_param.sv
// Parametrised instruction queue with registered decoder-facing output stage,
// fetch-PC tracking and flush/redirect on a ROB exception.
module iq_param
  import iq_param_pkg::*;
#(
  parameter int               DEPTH    = IQ_DEPTH,
  parameter int               PTR_W    = $clog2(DEPTH),
  parameter int               INSTR_W  = INSTR_LENGTH,
  parameter int               PC_W     = PC_LENGTH,
  parameter int               AFULL_TH = DEPTH - 2,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_exception_from_rob,
  input  logic [PC_W-1:0]    pc_from_rob,
  input  logic               is_hit_from_fetcher,
  input  logic [INSTR_W-1:0] instr_from_fetcher,
  input  logic               is_stall_from_rob,
  input  logic               is_stall_from_rs,
  input  logic               is_stall_from_slb,
  output logic [PC_W-1:0]    pc_to_fetcher,
  output logic               is_full_to_fetcher,
  output logic               is_afull_to_fetcher,
  output logic [PTR_W:0]     count_o,
  output logic               is_empty_to_decoder,
  output logic [INSTR_W-1:0] instr_to_decoder,
  output logic [PC_W-1:0]    pc_to_decoder
);

  localparam int ENTRY_W = INSTR_W + PC_W;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(AFULL_TH);

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W:0]     count;
  logic [PC_W-1:0]    pc_fc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  logic               dec_ready;
  logic               enq;
  logic               load;
  logic [ENTRY_W-1:0] rd_entry;

  assign dec_ready = !(is_stall_from_rob || is_stall_from_rs || is_stall_from_slb);
  // Full is judged on the start-of-cycle count, so a same-cycle dequeue never frees a slot.
  assign enq  = is_hit_from_fetcher && (count != FULL_CNT);
  assign load = (count != '0) && (!out_valid || dec_ready);

  iq_param_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (enq && !is_exception_from_rob),
    .waddr (tail),
    .wdata ({instr_from_fetcher, pc_fc}),
    .raddr (head),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pc_fc     <= RESET_PC;
      out_valid <= FALSE;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (is_exception_from_rob) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      pc_fc     <= pc_from_rob;
      out_valid <= FALSE;
    end else begin
      if (enq) begin
        tail  <= tail + PTR_W'(1);
        pc_fc <= pc_fc + PC_W'(PC_STEP);
      end
      if (load) begin
        out_valid <= TRUE;
        out_instr <= rd_entry[ENTRY_W-1:PC_W];
        out_pc    <= rd_entry[PC_W-1:0];
        head      <= head + PTR_W'(1);
      end else if (dec_ready) begin
        out_valid <= FALSE;
      end
      case ({enq, load})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign pc_to_fetcher       = pc_fc;
  assign is_full_to_fetcher  = (count == FULL_CNT);
  assign is_afull_to_fetcher = (count >= AFULL_CNT);
  assign count_o             = count;
  assign is_empty_to_decoder = !out_valid;
  assign instr_to_decoder    = out_instr;
  assign pc_to_decoder       = out_pc;

endmodule

// File: tb/tb_iq_param.sv
// Directed self-checking bench for iq_param (DEPTH=16, RESET_PC=0).
module tb_iq_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_exception_from_rob = 1'b0;
  logic [31:0] pc_from_rob = '0;
  logic        is_hit_from_fetcher = 1'b0;
  logic [31:0] instr_from_fetcher = '0;
  logic        is_stall_from_rob = 1'b0;
  logic        is_stall_from_rs = 1'b0;
  logic        is_stall_from_slb = 1'b0;
  logic [31:0] pc_to_fetcher;
  logic        is_full_to_fetcher;
  logic        is_afull_to_fetcher;
  logic [4:0]  count_o;
  logic        is_empty_to_decoder;
  logic [31:0] instr_to_decoder;
  logic [31:0] pc_to_decoder;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  iq_param dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_exception_from_rob (is_exception_from_rob),
    .pc_from_rob           (pc_from_rob),
    .is_hit_from_fetcher   (is_hit_from_fetcher),
    .instr_from_fetcher    (instr_from_fetcher),
    .is_stall_from_rob     (is_stall_from_rob),
    .is_stall_from_rs      (is_stall_from_rs),
    .is_stall_from_slb     (is_stall_from_slb),
    .pc_to_fetcher         (pc_to_fetcher),
    .is_full_to_fetcher    (is_full_to_fetcher),
    .is_afull_to_fetcher   (is_afull_to_fetcher),
    .count_o               (count_o),
    .is_empty_to_decoder   (is_empty_to_decoder),
    .instr_to_decoder      (instr_to_decoder),
    .pc_to_decoder         (pc_to_decoder)
  );

  // Clock: rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    is_exception_from_rob = 1'b0;
    is_hit_from_fetcher   = 1'b0;
    instr_from_fetcher    = '0;
    is_stall_from_rob     = 1'b0;
    is_stall_from_rs      = 1'b0;
    is_stall_from_slb     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    total_cnt++;
    if ({is_empty_to_decoder, is_full_to_fetcher, is_afull_to_fetcher, count_o} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      $display("FAIL reset_flags: got empty=%0b full=%0b afull=%0b count=%0d, want 1 0 0 0",
               is_empty_to_decoder, is_full_to_fetcher, is_afull_to_fetcher, count_o);
    end else pass_cnt++;
    total_cnt++;
    if ({pc_to_fetcher, instr_to_decoder, pc_to_decoder} !== 96'd0) begin
      $display("FAIL reset_data: got pcf=%h instr=%h pcd=%h, want all 0",
               pc_to_fetcher, instr_to_decoder, pc_to_decoder);
    end else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] instrs [3];
    instrs[0] = 32'h13; instrs[1] = 32'h93; instrs[2] = 32'h113;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      is_hit_from_fetcher = 1'b1;
      instr_from_fetcher  = instrs[i];
      step();
      if (i == 0) begin
        total_cnt++;
        if (is_empty_to_decoder !== 1'b1) begin
          $display("FAIL basic_empty_after_enq: got %0b want 1", is_empty_to_decoder);
        end else pass_cnt++;
      end else begin
        total_cnt++;
        if ({is_empty_to_decoder, pc_to_decoder, instr_to_decoder} !==
            {1'b0, 32'(4*(i-1)), instrs[i-1]}) begin
          $display("FAIL basic_out%0d: got empty=%0b pc=%h instr=%h want 0 %h %h",
                   i-1, is_empty_to_decoder, pc_to_decoder, instr_to_decoder, 4*(i-1), instrs[i-1]);
        end else pass_cnt++;
      end
    end
    is_hit_from_fetcher = 1'b0;
    total_cnt++;
    if (pc_to_fetcher !== 32'd12) begin
      $display("FAIL basic_pc_fetch: got %h want %h", pc_to_fetcher, 32'd12);
    end else pass_cnt++;
    step();
    total_cnt++;
    if ({is_empty_to_decoder, pc_to_decoder, instr_to_decoder} !== {1'b0, 32'd8, 32'h113}) begin
      $display("FAIL basic_out2: got empty=%0b pc=%h instr=%h want 0 8 113",
               is_empty_to_decoder, pc_to_decoder, instr_to_decoder);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (is_empty_to_decoder !== 1'b1) begin
      $display("FAIL basic_drain_empty: got %0b want 1", is_empty_to_decoder);
    end else pass_cnt++;
  endtask

  // Hits at edges 1..20 with the decoder stalled. Entry 0 moves into the output
  // stage at edge 2, so the queue holds k-1 entries after edge k and fills at edge 17.
  task automatic test_fill_and_full();
    do_reset();
    is_stall_from_rs = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      is_hit_from_fetcher = 1'b1;
      instr_from_fetcher  = 32'(k - 1);
      step();
      if (k == 14 || k == 15) begin
        total_cnt++;
        if (is_afull_to_fetcher !== (k == 15)) begin
          $display("FAIL fill_afull_k%0d: got %0b want %0b count=%0d", k, is_afull_to_fetcher, k == 15, count_o);
        end else pass_cnt++;
      end
      if (k == 16 || k == 17) begin
        total_cnt++;
        if (is_full_to_fetcher !== (k == 17)) begin
          $display("FAIL fill_full_k%0d: got %0b want %0b count=%0d", k, is_full_to_fetcher, k == 17, count_o);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if ({count_o, is_full_to_fetcher, pc_to_fetcher} !== {5'd16, 1'b1, 32'h44}) begin
      $display("FAIL fill_frozen: got count=%0d full=%0b pcf=%h want 16 1 44",
               count_o, is_full_to_fetcher, pc_to_fetcher);
    end else pass_cnt++;
    total_cnt++;
    if ({is_empty_to_decoder, pc_to_decoder, instr_to_decoder} !== {1'b0, 32'd0, 32'd0}) begin
      $display("FAIL fill_out_hold: got empty=%0b pc=%h instr=%h want 0 0 0",
               is_empty_to_decoder, pc_to_decoder, instr_to_decoder);
    end else pass_cnt++;
    // Full queue: hit and decoder-ready together.
    is_stall_from_rs    = 1'b0;
    is_hit_from_fetcher = 1'b1;
    instr_from_fetcher  = 32'hDEAD;
    step();
    is_hit_from_fetcher = 1'b0;
    total_cnt++;
    if ({count_o, is_full_to_fetcher, pc_to_fetcher} !== {5'd15, 1'b0, 32'h44}) begin
      $display("FAIL full_hit_ready: got count=%0d full=%0b pcf=%h want 15 0 44",
               count_o, is_full_to_fetcher, pc_to_fetcher);
    end else pass_cnt++;
    total_cnt++;
    if ({pc_to_decoder, instr_to_decoder} !== {32'd4, 32'd1}) begin
      $display("FAIL full_hit_advance: got pc=%h instr=%h want 4 1", pc_to_decoder, instr_to_decoder);
    end else pass_cnt++;
  endtask

  // 40 enqueues through a 16-entry ring with a fixed irregular stall pattern.
  task automatic test_wrap();
    logic [31:0] model_pc;
    int issued;
    int consumed;
    int cyc;
    logic ready;
    do_reset();
    exp_q.delete();
    model_pc = '0;
    issued = 0;
    consumed = 0;
    cyc = 0;
    while (consumed < 40 && cyc < 400) begin
      is_stall_from_rob = (cyc % 5 == 1);
      is_stall_from_rs  = (cyc % 7 == 3);
      is_stall_from_slb = (cyc % 4 == 2);
      ready = !(is_stall_from_rob || is_stall_from_rs || is_stall_from_slb);
      if (!is_empty_to_decoder && ready) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL wrap_extra: got pc=%h want no entry", pc_to_decoder);
        end else begin
          if (pc_to_decoder !== exp_q[0]) begin
            $display("FAIL wrap_order%0d: got pc=%h want %h", consumed, pc_to_decoder, exp_q[0]);
          end else pass_cnt++;
          void'(exp_q.pop_front());
        end
        consumed++;
      end
      is_hit_from_fetcher = (issued < 40) && !is_full_to_fetcher;
      instr_from_fetcher  = 32'(issued);
      if (is_hit_from_fetcher) begin
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
        issued++;
      end
      step();
      cyc++;
    end
    idle_inputs();
    total_cnt++;
    if (consumed != 40 || exp_q.size() != 0) begin
      $display("FAIL wrap_complete: got consumed=%0d left=%0d want 40 0", consumed, exp_q.size());
    end else pass_cnt++;
    total_cnt++;
    if (pc_to_fetcher !== 32'hA0) begin
      $display("FAIL wrap_pc_fetch: got %h want a0", pc_to_fetcher);
    end else pass_cnt++;
  endtask

  task automatic test_exception();
    do_reset();
    is_stall_from_rs = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      is_hit_from_fetcher = 1'b1;
      instr_from_fetcher  = 32'(k);
      step();
    end
    total_cnt++;
    if (count_o !== 5'd5) begin
      $display("FAIL exc_premise_count: got %0d want 5", count_o);
    end else pass_cnt++;
    is_exception_from_rob = 1'b1;
    pc_from_rob           = 32'h1000;
    instr_from_fetcher    = 32'hBAD;
    step();
    is_exception_from_rob = 1'b0;
    is_hit_from_fetcher   = 1'b0;
    total_cnt++;
    if ({count_o, is_empty_to_decoder, pc_to_fetcher} !== {5'd0, 1'b1, 32'h1000}) begin
      $display("FAIL exc_flush: got count=%0d empty=%0b pcf=%h want 0 1 1000",
               count_o, is_empty_to_decoder, pc_to_fetcher);
    end else pass_cnt++;
    is_stall_from_rs    = 1'b0;
    is_hit_from_fetcher = 1'b1;
    instr_from_fetcher  = 32'hABC;
    step();
    is_hit_from_fetcher = 1'b0;
    step();
    total_cnt++;
    if ({is_empty_to_decoder, pc_to_decoder, instr_to_decoder, pc_to_fetcher} !==
        {1'b0, 32'h1000, 32'hABC, 32'h1004}) begin
      $display("FAIL exc_redirect: got empty=%0b pc=%h instr=%h pcf=%h want 0 1000 abc 1004",
               is_empty_to_decoder, pc_to_decoder, instr_to_decoder, pc_to_fetcher);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    is_stall_from_rs = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      is_hit_from_fetcher = 1'b1;
      instr_from_fetcher  = 32'h100 + 32'(k);
      step();
    end
    is_hit_from_fetcher = 1'b0;
    total_cnt++;
    if ({count_o, is_empty_to_decoder} !== {5'd7, 1'b0}) begin
      $display("FAIL arst_premise: got count=%0d empty=%0b want 7 0", count_o, is_empty_to_decoder);
    end else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({count_o, is_empty_to_decoder, is_full_to_fetcher, is_afull_to_fetcher} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL arst_flags: got count=%0d empty=%0b full=%0b afull=%0b want 0 1 0 0",
               count_o, is_empty_to_decoder, is_full_to_fetcher, is_afull_to_fetcher);
    end else pass_cnt++;
    total_cnt++;
    if ({pc_to_fetcher, instr_to_decoder, pc_to_decoder} !== 96'd0) begin
      $display("FAIL arst_data: got pcf=%h instr=%h pcd=%h want all 0",
               pc_to_fetcher, instr_to_decoder, pc_to_decoder);
    end else pass_cnt++;
    step();
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_and_full();
    test_wrap();
    test_exception();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
